spi_pixel_sync: RTL and testbench

- Downstream stage of the SPI display front end. Takes the per-pixel output (x, y, RGB565 word) produced in the spi_clk domain and transfers it into the system clk domain.
- Transfer uses a toggle-flag handshake. Each pixel is bounds-checked, converted to a linear framebuffer address and buffered in a small FIFO.
- The FIFO is presented to the framebuffer writer over valid/ready.
- Also reports frame completion and drop/overflow status.

---
 rtl/spi_display_pkg.sv | 34 +++
 rtl/pixel_fifo.sv | 62 ++++++
 rtl/spi_pixel_sync.sv | 124 ++++++++++++
 tb/tb_spi_pixel_sync.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/spi_display_pkg.sv
// Shared definitions for the SPI display front end.
//   - Default visible resolution (H_RES_DEF x V_RES_DEF)
//   - RGB565 field positions
//   - ILI9340 command opcodes
//   - clog2 helper for deriving address/pointer widths
package spi_display_pkg;

  localparam int unsigned H_RES_DEF = 1024;
  localparam int unsigned V_RES_DEF = 768;

  localparam int unsigned RGB_R_MSB = 15;
  localparam int unsigned RGB_R_LSB = 11;
  localparam int unsigned RGB_G_MSB = 10;
  localparam int unsigned RGB_G_LSB = 5;
  localparam int unsigned RGB_B_MSB = 4;
  localparam int unsigned RGB_B_LSB = 0;

  typedef enum logic [7:0] {
    CMD_DISPOFF = 8'h28,
    CMD_DISPON  = 8'h29,
    CMD_CASET   = 8'h2A,
    CMD_PASET   = 8'h2B,
    CMD_RAMWR   = 8'h2C
  } ili9340_cmd_e;

  // Smallest r with 2^r >= value (0 for value <= 1).
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) r++;
    return r;
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Show-ahead FIFO used to buffer pixels in the clk domain.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   push/push_data write request and data
//   accept         push was taken this cycle (not full, or full with a pop)
//   pop            read request; ignored while empty
//   head           current head entry (valid when !empty)
//   full, empty    occupancy flags
module pixel_fifo
  import spi_display_pkg::*;
#(
  parameter int unsigned WIDTH = 36,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             accept,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW = clog2(DEPTH);
  localparam int unsigned CW = clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             pop_ok;

  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));
  assign pop_ok = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign accept = push && (!full || pop_ok);
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok) rd_ptr <= rd_ptr + PW'(1);
      case ({accept, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/spi_pixel_sync.sv
// Moves per-pixel results (x, y, RGB565) from the spi_clk domain into clk
// via a toggle handshake, bounds-checks them, converts to a linear
// framebuffer address and queues them in a show-ahead FIFO.
// Ports:
//   clk, reset_n          system clock, asynchronous active-low reset
//   pix_toggle            spi_clk domain, inverts once per pixel
//   pix_x, pix_y, pix_data spi_clk domain pixel bus, held stable after toggle
//   out_valid/out_ready   FIFO head handshake
//   out_addr, out_data    head entry (zero while empty)
//   frame_done            one-cycle pulse after the last pixel is queued
//   overflow              sticky: pixel lost to a full FIFO
//   drop_count            saturating count of discarded pixels
//   clear_status          synchronous clear of overflow/drop_count
module spi_pixel_sync
  import spi_display_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned H_RES      = H_RES_DEF,
  parameter int unsigned V_RES      = V_RES_DEF,
  parameter int unsigned ADDR_W     = 20,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              pix_toggle,
  input  logic [WIDTH-1:0]  pix_x,
  input  logic [WIDTH-1:0]  pix_y,
  input  logic [15:0]       pix_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [15:0]       out_data,
  output logic              frame_done,
  output logic              overflow,
  output logic [15:0]       drop_count,
  input  logic              clear_status
);

  localparam int unsigned EW = ADDR_W + 16;

  logic             sync0, sync1, sync_prev;
  logic [1:0]       arm_cnt;
  logic             armed, event_hit;
  logic             s1_valid;
  logic [WIDTH-1:0] s1_x, s1_y;
  logic [15:0]      s1_data;
  logic [31:0]      lin;
  logic             in_range, push, accept, full, empty, pop;
  logic             drop, ovf_drop;
  logic [EW-1:0]    head;

  // sync_prev keeps following sync1 while disarmed, so a toggle level held
  // across reset is absorbed before events are enabled.
  assign armed     = (arm_cnt == 2'd3);
  assign event_hit = armed && (sync1 ^ sync_prev);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync0     <= 1'b0;
      sync1     <= 1'b0;
      sync_prev <= 1'b0;
      arm_cnt   <= '0;
      s1_valid  <= 1'b0;
      s1_x      <= '0;
      s1_y      <= '0;
      s1_data   <= '0;
    end else begin
      sync0     <= pix_toggle;
      sync1     <= sync0;
      sync_prev <= sync1;
      if (!armed) arm_cnt <= arm_cnt + 2'd1;
      s1_valid  <= event_hit;
      if (event_hit) begin
        s1_x    <= pix_x;
        s1_y    <= pix_y;
        s1_data <= pix_data;
      end
    end
  end

  assign in_range = (32'(s1_x) < H_RES) && (32'(s1_y) < V_RES);
  assign lin      = 32'(s1_y) * H_RES + 32'(s1_x);
  assign push     = s1_valid && in_range;
  assign pop      = out_ready && !empty;
  assign ovf_drop = push && !accept;
  assign drop     = (s1_valid && !in_range) || ovf_drop;

  pixel_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data ({lin[ADDR_W-1:0], s1_data}),
    .accept    (accept),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  assign out_valid = !empty;
  assign out_addr  = out_valid ? head[EW-1:16] : '0;
  assign out_data  = out_valid ? head[15:0]    : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_done <= 1'b0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      frame_done <= accept && (lin == H_RES * V_RES - 1);
      if (clear_status) begin
        overflow   <= ovf_drop;
        drop_count <= drop ? 16'd1 : 16'd0;
      end else begin
        if (ovf_drop) overflow <= 1'b1;
        if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_spi_pixel_sync.sv
// Directed self-checking bench for spi_pixel_sync.
module tb_spi_pixel_sync;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        pix_toggle;
  logic [15:0] pix_x, pix_y, pix_data;
  logic        out_valid, out_ready;
  logic [19:0] out_addr;
  logic [15:0] out_data;
  logic        frame_done, overflow;
  logic [15:0] drop_count;
  logic        clear_status;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  spi_pixel_sync #(
    .WIDTH      (16),
    .H_RES      (1024),
    .V_RES      (768),
    .ADDR_W     (20),
    .FIFO_DEPTH (8)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pix_toggle   (pix_toggle),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .pix_data     (pix_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_addr     (out_addr),
    .out_data     (out_data),
    .frame_done   (frame_done),
    .overflow     (overflow),
    .drop_count   (drop_count),
    .clear_status (clear_status)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Caller is at a negedge: present a pixel and flip the toggle.
  task automatic put_px(input int x, input int y, input int d);
    pix_x      = 16'(x);
    pix_y      = 16'(y);
    pix_data   = 16'(d);
    pix_toggle = ~pix_toggle;
  endtask

  task automatic send_px(input int x, input int y, input int d, input int gap);
    put_px(x, y, d);
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0; pix_toggle = 1'b1; pix_x = '0; pix_y = '0; pix_data = '0;
    out_ready = 1'b0; clear_status = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_addr", 32'(out_addr), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_frame", 32'(frame_done), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_drop", 32'(drop_count), 0);

    // Toggle held high across reset release: no spurious pixel.
    reset_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("held_toggle_valid", 32'(out_valid), 0);
    end
    chk("held_toggle_drop", 32'(drop_count), 0);

    // Single pixel latency and address.
    put_px(3, 2, 16'hF800);
    repeat (3) @(negedge clk);
    chk("lat_not_yet", 32'(out_valid), 0);
    @(negedge clk);
    chk("lat_valid", 32'(out_valid), 1);
    chk("lat_addr", 32'(out_addr), 2051);
    chk("lat_data", 32'(out_data), 32'hF800);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("pop_empty", 32'(out_valid), 0);
    repeat (4) @(negedge clk);

    // Out-of-range pixels are dropped without touching overflow.
    send_px(1024, 0, 16'h1234, 8);
    send_px(0, 768, 16'h5678, 8);
    chk("oor_valid", 32'(out_valid), 0);
    chk("oor_drop", 32'(drop_count), 2);
    chk("oor_ovf", 32'(overflow), 0);

    // Clear alone.
    clear_status = 1'b1;
    @(negedge clk);
    clear_status = 1'b0;
    chk("clr_drop", 32'(drop_count), 0);
    chk("clr_ovf", 32'(overflow), 0);

    // Fill past capacity at the minimum 4x clock ratio.
    for (int i = 0; i < 10; i++) send_px(i, 0, 16'h1000 + i, 4);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_drop", 32'(drop_count), 2);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_valid", 32'(out_valid), 1);
      chk("drain_addr", 32'(out_addr), 32'(i));
      chk("drain_data", 32'(out_data), 32'h1000 + 32'(i));
      @(negedge clk);
    end
    chk("drain_done", 32'(out_valid), 0);
    out_ready = 1'b0;

    // Last pixel of the frame.
    put_px(1023, 767, 16'h07E0);
    repeat (3) @(negedge clk);
    chk("fd_before", 32'(frame_done), 0);
    @(negedge clk);
    chk("fd_pulse", 32'(frame_done), 1);
    chk("fd_addr", 32'(out_addr), 786431);
    chk("fd_data", 32'(out_data), 32'h07E0);
    @(negedge clk);
    chk("fd_after", 32'(frame_done), 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("fd_popped", 32'(out_valid), 0);

    // Clear coinciding with an overflow drop (drop_count was 2, overflow 1).
    for (int i = 0; i < 8; i++) send_px(100 + i, 1, 16'h2000 + i, 4);
    put_px(200, 1, 16'hBEEF);
    repeat (3) @(negedge clk);
    clear_status = 1'b1;
    @(negedge clk);
    chk("clr_drop_same_ovf", 32'(overflow), 1);
    chk("clr_drop_same_cnt", 32'(drop_count), 1);
    @(negedge clk);
    clear_status = 1'b0;
    chk("clr_next_ovf", 32'(overflow), 0);
    chk("clr_next_cnt", 32'(drop_count), 0);

    // Leave 3 entries queued, then reset asynchronously mid-cycle.
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    out_ready = 1'b0;
    chk("q3_valid", 32'(out_valid), 1);
    chk("q3_head", 32'(out_addr), 1024 + 105);
    #2 reset_n = 1'b0;
    #1;
    chk("async_valid", 32'(out_valid), 0);
    chk("async_addr", 32'(out_addr), 0);
    chk("async_data", 32'(out_data), 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_empty", 32'(out_valid), 0);
    send_px(5, 3, 16'h001F, 4);
    chk("post_rst_valid", 32'(out_valid), 1);
    chk("post_rst_addr", 32'(out_addr), 3077);
    chk("post_rst_data", 32'(out_data), 32'h001F);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_rst_single", 32'(out_valid), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
